pll_sweep_seq: RTL and testbench
================================

Name: pll_sweep_seq

Overview:
- Sequencer that steps the PLL through a range of DRP configuration addresses.
- For each point it:
  - issues a reconfiguration request to the PLL DRP engine (PLL_ADDR/PLL_CHG, SRDY handshake);
  - waits for a qualified PLL lock;
  - opens a fixed-length measurement window.
- Sits beside pll_ctrl in the CLK (DRP/system clock) domain. It drives pll_ctrl's PLL_ADDR/PLL_CHG inputs and consumes the DRP SRDY and PLL LOCKED status for clock-skew sweeps.

Parameters:
- DW, 16, width of DWELL input and dwell counter
- TW, 20, width of handshake/lock timeout counter
- TIMEOUT, 20'd1000000, max CLK cycles allowed in WAIT_SRDY or WAIT_LOCK before error
- LOCK_STABLE, 16, consecutive cycles PLL_LOCK must be high to qualify lock (>=1)

Ports:
- CLK  in  1  system/DRP clock; all logic on posedge
- RST  in  1  synchronous reset, active-high
- START  in  1  one-cycle sweep start request
- ABORT  in  1  stop sweep immediately
- ADDR_FIRST  in  8  first DRP configuration address
- ADDR_LAST  in  8  last DRP configuration address
- LOOP  in  1  1 = restart at ADDR_FIRST after ADDR_LAST, forever
- DWELL  in  DW  measurement window length in cycles (0 treated as 1)
- PLL_ADDR  out  8  configuration address to DRP engine, registered
- PLL_CHG  out  1  one-cycle reconfiguration request, registered
- PLL_SRDY  in  1  one-cycle DRP-done pulse from DRP engine
- PLL_LOCK  in  1  PLL LOCKED, already synchronous to CLK
- BUSY  out  1  high in every state except IDLE
- MEAS_EN  out  1  measurement window, high only in DWELL
- DONE  out  1  one-cycle pulse, non-loop sweep finished
- ERR  out  1  sticky timeout/lock-loss flag, cleared by accepted START

Behaviour:
- Reset: state IDLE, all outputs 0. RST has priority over all inputs.
- States: IDLE, ISSUE, WAIT_SRDY, WAIT_LOCK, DWELL, NEXT, FAIL.
- ABORT, non-IDLE state: next state IDLE with PLL_CHG, MEAS_EN, DONE low; ERR unchanged. A DRP transfer in flight completes on its own; a late SRDY in IDLE is ignored.
- ABORT in IDLE: START in the same cycle is ignored. START in any non-IDLE state is ignored.
- IDLE + START:
  - latch ADDR_FIRST, ADDR_LAST, DWELL, LOOP;
  - PLL_ADDR <= ADDR_FIRST; ERR <= 0;
  - direction up if ADDR_FIRST <= ADDR_LAST, else down;
  - go ISSUE.
- ISSUE: PLL_CHG = 1 for exactly this cycle, i.e. the cycle after START is sampled. Load timeout counter with TIMEOUT; go WAIT_SRDY.
- WAIT_SRDY: on PLL_SRDY go WAIT_LOCK, reload timeout counter and clear stable count. On counter reaching 0 go FAIL.
- WAIT_LOCK: stable count increments while PLL_LOCK = 1 and clears to 0 on any low cycle. When count == LOCK_STABLE, go DWELL and load the dwell counter with max(DWELL, 1). On timeout go FAIL.
- DWELL: MEAS_EN = 1 for exactly max(DWELL, 1) cycles, then go NEXT. PLL_LOCK low in any DWELL cycle goes to FAIL immediately, with MEAS_EN low next cycle.
- NEXT (1 cycle):
  - PLL_ADDR != last: PLL_ADDR +/- 1 per direction, go ISSUE.
  - PLL_ADDR == last, LOOP = 1: PLL_ADDR <= first, go ISSUE.
  - PLL_ADDR == last, LOOP = 0: DONE = 1 for one cycle, go IDLE.
  - first == last is a single-point sweep. Address never wraps 255->0 or 0->255.
- FAIL (1 cycle): ERR <= 1, go IDLE; no DONE.
- Per-point cycle count, no stalls: 1 (ISSUE) + SRDY latency + LOCK_STABLE + max(DWELL, 1) + 1 (NEXT).

Decomposition:
- Shared header pll_sweep_defs.vh:
  - state encodings (3-bit localparams);
  - default DW, TW, TIMEOUT, LOCK_STABLE.
- One sub-module, lock_qual:
  - inputs CLK, RST, CLR, LOCK_IN; output QUAL;
  - parameter LOCK_STABLE;
  - saturating consecutive-high counter used in WAIT_LOCK.

Test Plan:
- FIRST=3, LAST=5, DWELL=4, LOOP=0, SRDY 10 cycles after each PLL_CHG, LOCK high 20 cycles after SRDY -> PLL_CHG pulses with PLL_ADDR 3, 4, 5; three MEAS_EN windows of exactly 4 cycles; one DONE; ERR = 0.
- FIRST=7, LAST=5 -> addresses 7, 6, 5 in order. FIRST=LAST=9 -> one PLL_CHG, one window, DONE.
- Reverse wrap check: FIRST=255, LAST=254 -> descends 255 then 254, no wrap. FIRST=LAST=0 with LOOP=0 -> single point.
- LOOP=1, FIRST=1, LAST=2 -> address sequence 1, 2, 1, 2, ... and no DONE; ABORT mid-DWELL -> IDLE next cycle, MEAS_EN and BUSY low, no DONE.
- SRDY never arrives (TIMEOUT = 50) -> ERR = 1 after 50 cycles in WAIT_SRDY; BUSY low; next START clears ERR. LOCK dropped at dwell cycle 2 -> FAIL, ERR = 1.
- LOCK glitch low at stable count 15 of 16 -> count restarts, MEAS_EN delayed by 16 more cycles. DWELL=0 -> 1-cycle window. RST asserted mid-sweep -> all outputs 0 on next cycle.

Source files
------------

// File: rtl/pll_sweep_seq_pkg.sv
// pll_sweep_seq_pkg: shared definitions for the PLL DRP sweep sequencer.
//   - sweep_state_e : FSM state encoding (3 bits)
//   - DEF_*         : default widths, timeout and lock qualification length
//   - step_addr()   : one address step in the sweep direction
package pll_sweep_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_SRDY = 3'd2,
      ST_WAIT_LOCK = 3'd3,
      ST_DWELL     = 3'd4,
      ST_NEXT      = 3'd5,
      ST_FAIL      = 3'd6
   } sweep_state_e;

   localparam int unsigned DEF_DW          = 16;
   localparam int unsigned DEF_TW          = 20;
   localparam logic [19:0] DEF_TIMEOUT     = 20'd1000000;
   localparam int unsigned DEF_LOCK_STABLE = 16;

   function automatic logic [7:0] step_addr(input logic [7:0] addr, input logic up);
      return up ? addr + 8'd1 : addr - 8'd1;
   endfunction

endpackage

// File: rtl/pll_sweep_seq_lock_qual.sv
// pll_sweep_seq_lock_qual: qualifies PLL LOCKED as stable once it has been
// high for LOCK_STABLE consecutive cycles.
//   clk_i  : system/DRP clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : restart qualification (held while not waiting for lock)
//   lock_i : PLL LOCKED, synchronous to clk_i
//   qual_o : high in the cycle that completes LOCK_STABLE consecutive highs
module pll_sweep_seq_lock_qual
   import pll_sweep_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic lock_i,
   output logic qual_o
);

   localparam int unsigned   CW      = $clog2(LOCK_STABLE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE);
   localparam logic [CW-1:0] CNT_PRE = CW'(LOCK_STABLE - 1);

   logic [CW-1:0] cnt_q;

   // Saturating count of consecutive high cycles; any low cycle restarts it.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i || !lock_i) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // The current high cycle is counted in, so the FSM leaves WAIT_LOCK
   // after exactly LOCK_STABLE high cycles.
   assign qual_o = lock_i && !clr_i && (cnt_q >= CNT_PRE);

endmodule

// File: rtl/pll_sweep_seq.sv
// pll_sweep_seq: steps a PLL through DRP configuration addresses. For each
// point it requests a reconfiguration, waits for DRP done and a qualified
// lock, then opens a measurement window.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   start_i, abort_i           : sweep start (one cycle) / immediate stop
//   addr_first_i, addr_last_i  : sweep range, either direction
//   loop_i, dwell_i            : repeat forever / window length (0 -> 1)
//   pll_addr_o, pll_chg_o      : request to the DRP engine
//   pll_srdy_i, pll_lock_i     : DRP done pulse, PLL LOCKED
//   busy_o, meas_en_o, done_o  : status, measurement window, sweep done
//   err_o                      : sticky timeout / lock-loss flag
//
// state     | meaning
// IDLE      | waiting for START
// ISSUE     | PLL_CHG pulse, timeout loaded
// WAIT_SRDY | waiting for DRP done
// WAIT_LOCK | waiting for LOCK_STABLE consecutive lock cycles
// DWELL     | measurement window open
// NEXT      | advance address, loop or finish
// FAIL      | timeout or lock loss, set ERR
module pll_sweep_seq
   import pll_sweep_seq_pkg::*;
#(
   parameter int unsigned    DW          = DEF_DW,
   parameter int unsigned    TW          = DEF_TW,
   parameter logic [TW-1:0]  TIMEOUT     = TW'(DEF_TIMEOUT),
   parameter int unsigned    LOCK_STABLE = DEF_LOCK_STABLE
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [7:0]    addr_first_i,
   input  logic [7:0]    addr_last_i,
   input  logic          loop_i,
   input  logic [DW-1:0] dwell_i,
   output logic [7:0]    pll_addr_o,
   output logic          pll_chg_o,
   input  logic          pll_srdy_i,
   input  logic          pll_lock_i,
   output logic          busy_o,
   output logic          meas_en_o,
   output logic          done_o,
   output logic          err_o
);

   sweep_state_e  state_q;
   logic [7:0]    first_q, last_q, pll_addr_q;
   logic          up_q, loop_q;
   logic [DW-1:0] dwell_len_q, dwell_cnt_q;
   logic [TW-1:0] tmo_q;
   logic          pll_chg_q, busy_q, meas_en_q, done_q, err_q;
   logic          lock_clr, lock_qual;
   logic [DW-1:0] dwell_len_d;

   assign dwell_len_d = (dwell_i == '0) ? DW'(1) : dwell_i;
   assign lock_clr    = (state_q != ST_WAIT_LOCK);

   pll_sweep_seq_lock_qual #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_qual (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (lock_clr),
      .lock_i (pll_lock_i),
      .qual_o (lock_qual)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         first_q     <= '0;
         last_q      <= '0;
         pll_addr_q  <= '0;
         up_q        <= 1'b0;
         loop_q      <= 1'b0;
         dwell_len_q <= '0;
         dwell_cnt_q <= '0;
         tmo_q       <= '0;
         pll_chg_q   <= 1'b0;
         busy_q      <= 1'b0;
         meas_en_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pll_chg_q <= 1'b0;
         done_q    <= 1'b0;
         if (abort_i && (state_q != ST_IDLE)) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            meas_en_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (start_i && !abort_i) begin
                     first_q     <= addr_first_i;
                     last_q      <= addr_last_i;
                     up_q        <= (addr_first_i <= addr_last_i);
                     loop_q      <= loop_i;
                     dwell_len_q <= dwell_len_d;
                     pll_addr_q  <= addr_first_i;
                     err_q       <= 1'b0;
                     pll_chg_q   <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= ST_ISSUE;
                  end
               end
               ST_ISSUE: begin
                  tmo_q   <= TIMEOUT;
                  state_q <= ST_WAIT_SRDY;
               end
               ST_WAIT_SRDY: begin
                  if (pll_srdy_i) begin
                     tmo_q   <= TIMEOUT;
                     state_q <= ST_WAIT_LOCK;
                  end else if (tmo_q <= TW'(1)) begin
                     state_q <= ST_FAIL;
                  end else begin
                     tmo_q <= tmo_q - TW'(1);
                  end
               end
               ST_WAIT_LOCK: begin
                  if (lock_qual) begin
                     dwell_cnt_q <= dwell_len_q;
                     meas_en_q   <= 1'b1;
                     state_q     <= ST_DWELL;
                  end else if (tmo_q <= TW'(1)) begin
                     state_q <= ST_FAIL;
                  end else begin
                     tmo_q <= tmo_q - TW'(1);
                  end
               end
               ST_DWELL: begin
                  if (!pll_lock_i) begin
                     meas_en_q <= 1'b0;
                     state_q   <= ST_FAIL;
                  end else if (dwell_cnt_q <= DW'(1)) begin
                     meas_en_q <= 1'b0;
                     state_q   <= ST_NEXT;
                  end else begin
                     dwell_cnt_q <= dwell_cnt_q - DW'(1);
                  end
               end
               ST_NEXT: begin
                  // Stepping stops at last, so the address never wraps.
                  if (pll_addr_q != last_q) begin
                     pll_addr_q <= step_addr(pll_addr_q, up_q);
                     pll_chg_q  <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end else if (loop_q) begin
                     pll_addr_q <= first_q;
                     pll_chg_q  <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
               ST_FAIL: begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  busy_q    <= 1'b0;
                  meas_en_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign pll_addr_o = pll_addr_q;
   assign pll_chg_o  = pll_chg_q;
   assign busy_o     = busy_q;
   assign meas_en_o  = meas_en_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_pll_sweep_seq.sv
// Directed bench for pll_sweep_seq. A DRP/PLL responder answers each
// PLL_CHG with SRDY after srdy_delay cycles and LOCK lock_delay cycles later.
module tb_pll_sweep_seq;

   logic        clk = 1'b0;
   logic        rst_i, start_i, abort_i, loop_i;
   logic [7:0]  addr_first_i, addr_last_i;
   logic [15:0] dwell_i;
   logic [7:0]  pll_addr_o;
   logic        pll_chg_o, pll_srdy_i, pll_lock_i;
   logic        busy_o, meas_en_o, done_o, err_o;

   always #5 clk = ~clk;

   pll_sweep_seq #(
      .DW          (16),
      .TW          (20),
      .TIMEOUT     (20'd50),
      .LOCK_STABLE (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .addr_first_i (addr_first_i),
      .addr_last_i  (addr_last_i),
      .loop_i       (loop_i),
      .dwell_i      (dwell_i),
      .pll_addr_o   (pll_addr_o),
      .pll_chg_o    (pll_chg_o),
      .pll_srdy_i   (pll_srdy_i),
      .pll_lock_i   (pll_lock_i),
      .busy_o       (busy_o),
      .meas_en_o    (meas_en_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   // ---------------- responder ----------------
   int srdy_delay  = 10;
   int lock_delay  = 20;
   bit lock_follow = 1'b1;
   bit lock_model  = 1'b0;
   bit lock_kill   = 1'b0;
   int srdy_cd     = 0;
   int lock_cd     = 0;

   assign pll_lock_i = lock_model & ~lock_kill;

   initial begin
      pll_srdy_i = 1'b0;
      forever begin
         @(negedge clk);
         pll_srdy_i = 1'b0;
         if (lock_cd > 0) begin
            lock_cd--;
            if (lock_cd == 0) lock_model = 1'b1;
         end
         if (srdy_cd > 0) begin
            srdy_cd--;
            if (srdy_cd == 0) begin
               pll_srdy_i = 1'b1;
               if (lock_delay == 0) lock_model = 1'b1;
               else lock_cd = lock_delay;
            end
         end
         if (pll_chg_o === 1'b1 && rst_i === 1'b0) begin
            if (srdy_delay > 0) srdy_cd = srdy_delay;
            if (lock_follow) begin
               lock_model = 1'b0;
               lock_cd    = 0;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int         cyc = 0;
   logic [7:0] addr_log[$];
   int         chg_time[$];
   int         win_log[$];
   int         win_run  = 0;
   int         done_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (pll_chg_o === 1'b1) begin
            addr_log.push_back(pll_addr_o);
            chg_time.push_back(cyc);
         end
         if (meas_en_o === 1'b1) win_run++;
         else if (win_run > 0) begin
            win_log.push_back(win_run);
            win_run = 0;
         end
         if (done_o === 1'b1) done_cnt++;
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      chg_time.delete();
      win_log.delete();
      win_run  = 0;
      done_cnt = 0;
   endtask

   task automatic start_sweep(input logic [7:0] f, input logic [7:0] l,
                              input logic [15:0] d, input logic lp);
      @(negedge clk);
      addr_first_i = f;
      addr_last_i  = l;
      dwell_i      = d;
      loop_i       = lp;
      start_i      = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < max_cyc) begin
         @(negedge clk);
         n++;
         if (busy_o === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_meas(input int max_cyc, output bit ok);
      int n = 0;
      ok = (meas_en_o === 1'b1);
      while (!ok && n < max_cyc) begin
         @(negedge clk);
         n++;
         ok = (meas_en_o === 1'b1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; loop_i = 1'b0;
      addr_first_i = 8'd0; addr_last_i = 8'd0; dwell_i = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(busy_o),     32'd0);
      chk("rst_chg",   32'(pll_chg_o),  32'd0);
      chk("rst_meas",  32'(meas_en_o),  32'd0);
      chk("rst_done",  32'(done_o),     32'd0);
      chk("rst_err",   32'(err_o),      32'd0);
      chk("rst_addr",  32'(pll_addr_o), 32'd0);
      rst_i = 1'b0;

      // START with ABORT in IDLE is ignored
      @(negedge clk);
      start_i = 1'b1; abort_i = 1'b1; addr_first_i = 8'd3;
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0;
      chk("abort_idle_busy", 32'(busy_o),    32'd0);
      chk("abort_idle_chg",  32'(pll_chg_o), 32'd0);

      // up sweep 3..5
      clear_logs();
      start_sweep(8'd3, 8'd5, 16'd4, 1'b0);
      chk("up_chg_first", 32'(pll_chg_o), 32'd1);
      wait_idle(400, ok);
      chk("up_finish", 32'(ok), 32'd1);
      chk("up_npts",   32'(addr_log.size()), 32'd3);
      chk("up_a0",     32'(addr_log[0]), 32'd3);
      chk("up_a1",     32'(addr_log[1]), 32'd4);
      chk("up_a2",     32'(addr_log[2]), 32'd5);
      chk("up_nwin",   32'(win_log.size()), 32'd3);
      chk("up_w0",     32'(win_log[0]), 32'd4);
      chk("up_w2",     32'(win_log[2]), 32'd4);
      chk("up_done",   32'(done_cnt), 32'd1);
      chk("up_err",    32'(err_o), 32'd0);
      chk("up_gap",    32'(chg_time[1] - chg_time[0]), 32'd51);

      // down sweep 7..5
      clear_logs();
      start_sweep(8'd7, 8'd5, 16'd4, 1'b0);
      wait_idle(400, ok);
      chk("dn_finish", 32'(ok), 32'd1);
      chk("dn_npts",   32'(addr_log.size()), 32'd3);
      chk("dn_a0",     32'(addr_log[0]), 32'd7);
      chk("dn_a1",     32'(addr_log[1]), 32'd6);
      chk("dn_a2",     32'(addr_log[2]), 32'd5);
      chk("dn_done",   32'(done_cnt), 32'd1);

      // single point 9
      clear_logs();
      start_sweep(8'd9, 8'd9, 16'd2, 1'b0);
      wait_idle(200, ok);
      chk("sp9_finish", 32'(ok), 32'd1);
      chk("sp9_npts",   32'(addr_log.size()), 32'd1);
      chk("sp9_a0",     32'(addr_log[0]), 32'd9);
      chk("sp9_nwin",   32'(win_log.size()), 32'd1);
      chk("sp9_w0",     32'(win_log[0]), 32'd2);
      chk("sp9_done",   32'(done_cnt), 32'd1);

      // 255 -> 254, no wrap
      clear_logs();
      start_sweep(8'd255, 8'd254, 16'd1, 1'b0);
      wait_idle(300, ok);
      chk("top_finish", 32'(ok), 32'd1);
      chk("top_npts",   32'(addr_log.size()), 32'd2);
      chk("top_a0",     32'(addr_log[0]), 32'd255);
      chk("top_a1",     32'(addr_log[1]), 32'd254);

      // single point 0
      clear_logs();
      start_sweep(8'd0, 8'd0, 16'd1, 1'b0);
      wait_idle(200, ok);
      chk("sp0_npts", 32'(addr_log.size()), 32'd1);
      chk("sp0_a0",   32'(addr_log[0]), 32'd0);
      chk("sp0_done", 32'(done_cnt), 32'd1);

      // loop 1,2 then abort mid-dwell
      clear_logs();
      start_sweep(8'd1, 8'd2, 16'd4, 1'b1);
      n = 0;
      while (addr_log.size() < 5 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("loop_reach5", 32'(addr_log.size() >= 5), 32'd1);
      wait_meas(100, ok);
      chk("loop_meas", 32'(ok), 32'd1);
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_meas", 32'(meas_en_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_err",  32'(err_o), 32'd0);
      repeat (30) @(negedge clk);
      chk("abort_stay_idle", 32'(busy_o), 32'd0);
      chk("loop_npts", 32'(addr_log.size()), 32'd5);
      chk("loop_a0",   32'(addr_log[0]), 32'd1);
      chk("loop_a1",   32'(addr_log[1]), 32'd2);
      chk("loop_a2",   32'(addr_log[2]), 32'd1);
      chk("loop_a3",   32'(addr_log[3]), 32'd2);
      chk("loop_a4",   32'(addr_log[4]), 32'd1);
      chk("loop_done", 32'(done_cnt), 32'd0);

      // SRDY never arrives
      clear_logs();
      srdy_delay = -1;
      start_sweep(8'd10, 8'd12, 16'd4, 1'b0);
      n = 0;
      while (err_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd52);
      chk("tmo_busy",   32'(busy_o), 32'd0);
      chk("tmo_err",    32'(err_o), 32'd1);
      chk("tmo_done",   32'(done_cnt), 32'd0);

      // next START clears ERR
      srdy_delay = 10;
      clear_logs();
      start_sweep(8'd10, 8'd10, 16'd1, 1'b0);
      chk("errclr_start", 32'(err_o), 32'd0);
      wait_idle(200, ok);
      chk("errclr_done", 32'(done_cnt), 32'd1);
      chk("errclr_err",  32'(err_o), 32'd0);

      // lock lost in dwell cycle 2
      clear_logs();
      start_sweep(8'd20, 8'd22, 16'd5, 1'b0);
      wait_meas(200, ok);
      chk("ldrop_meas", 32'(ok), 32'd1);
      @(negedge clk);
      lock_kill = 1'b1;
      @(negedge clk);
      lock_kill = 1'b0;
      chk("ldrop_meas_off", 32'(meas_en_o), 32'd0);
      chk("ldrop_err_fail", 32'(err_o), 32'd0);
      @(negedge clk);
      chk("ldrop_err",  32'(err_o), 32'd1);
      chk("ldrop_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      chk("ldrop_win",  32'(win_log[0]), 32'd2);
      chk("ldrop_done", 32'(done_cnt), 32'd0);

      // lock glitch at stable count 15, PLL otherwise always locked
      lock_follow = 1'b0;
      lock_model  = 1'b1;
      srdy_delay  = 1;
      clear_logs();
      start_sweep(8'd30, 8'd30, 16'd3, 1'b0);
      repeat (17) @(negedge clk);
      lock_kill = 1'b1;
      @(negedge clk);
      lock_kill = 1'b0;
      n = 0;
      while (meas_en_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("glitch_delay", 32'(n), 32'd16);
      wait_idle(100, ok);
      chk("glitch_win",  32'(win_log[0]), 32'd3);
      chk("glitch_done", 32'(done_cnt), 32'd1);

      // DWELL = 0, no stalls
      clear_logs();
      start_sweep(8'd40, 8'd41, 16'd0, 1'b0);
      wait_idle(200, ok);
      chk("dw0_nwin", 32'(win_log.size()), 32'd2);
      chk("dw0_w0",   32'(win_log[0]), 32'd1);
      chk("dw0_w1",   32'(win_log[1]), 32'd1);
      chk("dw0_gap",  32'(chg_time[1] - chg_time[0]), 32'd20);
      chk("dw0_a1",   32'(addr_log[1]), 32'd41);
      chk("dw0_done", 32'(done_cnt), 32'd1);

      // reset mid-sweep
      lock_follow = 1'b1;
      srdy_delay  = 10;
      clear_logs();
      start_sweep(8'd50, 8'd60, 16'd4, 1'b0);
      wait_meas(200, ok);
      chk("rstmid_meas", 32'(ok), 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("rstmid_busy", 32'(busy_o),     32'd0);
      chk("rstmid_meas_off", 32'(meas_en_o), 32'd0);
      chk("rstmid_chg",  32'(pll_chg_o),  32'd0);
      chk("rstmid_done", 32'(done_o),     32'd0);
      chk("rstmid_err",  32'(err_o),      32'd0);
      chk("rstmid_addr", 32'(pll_addr_o), 32'd0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
